// File: rtl/trigger_fill_renderer.sv
// Trigger fill sprite renderer: maps VGA coordinates onto the sprite ROM, aligns sync and
// background with the ROM read latency, and shades white sprite pixels by a smoothed trigger level.
module trigger_fill_renderer #(
    parameter int unsigned   SPRITE_W    = 584,
    parameter int unsigned   SPRITE_H    = 167,
    parameter int unsigned   X0          = 28,
    parameter int unsigned   Y0          = 300,
    parameter int unsigned   STEP        = 16,
    parameter logic [11:0]   FILL_COLOR  = 12'hF00,
    parameter logic [11:0]   EMPTY_COLOR = 12'h444
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        video_on,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        frame_tick,
    input  logic [7:0]  trigger_level,
    input  logic [11:0] bg_rgb,
    output logic [7:0]  rom_row,
    output logic [9:0]  rom_col,
    input  logic [11:0] rom_data,
    output logic [11:0] rgb_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic [7:0]  level_disp
);

    localparam logic [10:0] X_LO  = 11'(X0);
    localparam logic [10:0] X_HI  = 11'(X0 + SPRITE_W);
    localparam logic [10:0] Y_LO  = 11'(Y0);
    localparam logic [10:0] Y_HI  = 11'(Y0 + SPRITE_H);
    localparam logic [8:0]  STEP9 = 9'(STEP);
    localparam logic [7:0]  STEP8 = 8'(STEP);
    localparam logic [17:0] W18   = 18'(SPRITE_W);
    localparam logic [9:0]  W10   = 10'(SPRITE_W);

    // address generation
    logic in_sprite;

    always_comb begin
        in_sprite = ({1'b0, pixel_x} >= X_LO) && ({1'b0, pixel_x} < X_HI) &&
                    ({1'b0, pixel_y} >= Y_LO) && ({1'b0, pixel_y} < Y_HI);
        rom_col   = '0;
        rom_row   = '0;
        if (in_sprite) begin
            rom_col = pixel_x - 10'(X0);
            rom_row = 8'(pixel_y - 10'(Y0));
        end
    end

    // stage 1 registers (aligned with rom_data)
    logic        in_sprite_q, in_sprite_d;
    logic [9:0]  col_q, col_d;
    logic        video_on_q, video_on_d;
    logic        hsync_s1_q, hsync_s1_d;
    logic        vsync_s1_q, vsync_s1_d;
    logic [11:0] bg_q, bg_d;

    // stage 2 registers
    logic [11:0] rgb_q, rgb_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;

    // level smoothing and fill width
    logic [7:0]  level_q, level_d;
    logic        tick_q, tick_d;
    logic [9:0]  fill_q, fill_d;
    logic [8:0]  diff;
    logic [17:0] prod;

    always_comb begin
        in_sprite_d = in_sprite;
        col_d       = rom_col;
        video_on_d  = video_on;
        hsync_s1_d  = hsync_in;
        vsync_s1_d  = vsync_in;
        bg_d        = bg_rgb;

        hsync_d = hsync_s1_q;
        vsync_d = vsync_s1_q;
        rgb_d   = bg_q;
        if (!video_on_q) begin
            rgb_d = '0;
        end else if (in_sprite_q && rom_data == 12'hFFF) begin
            rgb_d = (col_q < fill_q) ? FILL_COLOR : EMPTY_COLOR;
        end
    end

    // step toward the target by at most STEP, landing exactly on it when closer
    always_comb begin
        level_d = level_q;
        diff    = '0;
        if (frame_tick) begin
            if (trigger_level > level_q) begin
                diff    = {1'b0, trigger_level} - {1'b0, level_q};
                level_d = (diff > STEP9) ? level_q + STEP8 : trigger_level;
            end else if (trigger_level < level_q) begin
                diff    = {1'b0, level_q} - {1'b0, trigger_level};
                level_d = (diff > STEP9) ? level_q - STEP8 : trigger_level;
            end
        end
    end

    // fill width follows the level one cycle after the tick, still inside blanking
    always_comb begin
        tick_d = frame_tick;
        prod   = 18'(level_q) * W18;
        fill_d = fill_q;
        if (tick_q) begin
            fill_d = (level_q == 8'hFF) ? W10 : 10'(prod >> 8);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_sprite_q <= 1'b0;
            col_q       <= '0;
            video_on_q  <= 1'b0;
            hsync_s1_q  <= 1'b1;
            vsync_s1_q  <= 1'b1;
            bg_q        <= '0;
            rgb_q       <= '0;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            level_q     <= '0;
            tick_q      <= 1'b0;
            fill_q      <= '0;
        end else begin
            in_sprite_q <= in_sprite_d;
            col_q       <= col_d;
            video_on_q  <= video_on_d;
            hsync_s1_q  <= hsync_s1_d;
            vsync_s1_q  <= vsync_s1_d;
            bg_q        <= bg_d;
            rgb_q       <= rgb_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            level_q     <= level_d;
            tick_q      <= tick_d;
            fill_q      <= fill_d;
        end
    end

    assign rgb_out    = rgb_q;
    assign hsync_out  = hsync_q;
    assign vsync_out  = vsync_q;
    assign level_disp = level_q;

endmodule
